// File: rtl/fifo_sync_param.sv
// Single-clock elastic FIFO with fill count, programmable almost flags and any DEPTH >= 2.
// Define FIFO_FWFT_EN for first-word-fall-through reads; the default build uses a registered read.
module fifo_sync_param #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int PTR_WIDTH     = $clog2(DEPTH),
  parameter int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     w_data,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     r_data,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 wr_error,
  output logic                 rd_error
);

  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_CNT   = CNT_WIDTH'(AFULL_THRESH);
  localparam logic [CNT_WIDTH-1:0] AE_CNT   = CNT_WIDTH'(AEMPTY_THRESH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 wr_acc;
  logic                 rd_acc;

  // Pointers wrap by explicit compare so DEPTH need not be a power of two.
  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // A read frees the slot the write lands in, so a full FIFO still accepts a write alongside it.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_error <= 1'b0;
      rd_error <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
      if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
      if (wr_acc && !rd_acc)      count <= count + 1'b1;
      else if (rd_acc && !wr_acc) count <= count - 1'b1;
      wr_error <= wr_en && !wr_acc;
      rd_error <= rd_en && !rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= w_data;
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented combinationally; rd_en only pops it.
  assign r_data = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_data <= '0;
    else if (rd_acc) r_data <= mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: DEPTH=16 and DEPTH=5 instances share stimulus; a queue model feeds a scoreboard.
module tb_fifo_sync_param;
  localparam int D  [2] = '{16, 5};
  localparam int AF [2] = '{14, 4};
  localparam int AE [2] = '{2, 1};

  typedef struct {
    int         cnt;
    bit         werr;
    bit         rerr;
    bit         dchk;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] w_data = 8'h00;

  logic [7:0] r_data_o [2];
  logic       full_o [2];
  logic       empty_o [2];
  logic       af_o [2];
  logic       ae_o [2];
  logic       werr_o [2];
  logic       rerr_o [2];
  logic [4:0] cnt16;
  logic [2:0] cnt5;

  int total = 0;
  int bad = 0;

  logic [7:0] mq [2][$];
  exp_t       eq [2][$];
  logic [7:0] hold [2];

  always #5 clk = ~clk;

  fifo_sync_param #(.WIDTH(8), .DEPTH(16)) dut16 (
    .clk(clk), .rst(rst), .w_data(w_data), .wr_en(wr_en), .rd_en(rd_en),
    .r_data(r_data_o[0]), .full(full_o[0]), .empty(empty_o[0]),
    .almost_full(af_o[0]), .almost_empty(ae_o[0]), .count(cnt16),
    .wr_error(werr_o[0]), .rd_error(rerr_o[0])
  );

  fifo_sync_param #(.WIDTH(8), .DEPTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) dut5 (
    .clk(clk), .rst(rst), .w_data(w_data), .wr_en(wr_en), .rd_en(rd_en),
    .r_data(r_data_o[1]), .full(full_o[1]), .empty(empty_o[1]),
    .almost_full(af_o[1]), .almost_empty(ae_o[1]), .count(cnt5),
    .wr_error(werr_o[1]), .rd_error(rerr_o[1])
  );

  function automatic int cnt_of(input int i);
    return (i == 0) ? int'(cnt16) : int'(cnt5);
  endfunction

  task automatic check(input string nm, input int i, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s depth=%0d actual=%0h required=%0h at %0t", nm, D[i], act, req, $time);
    end
  endtask

  // Reference model: a plain queue per instance, updated from the inputs the next edge will see.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      bit   racc;
      bit   wacc;
      if (!rst) begin
        mq[i].delete();
        eq[i].delete();
        hold[i] = 8'h00;
      end else begin
        racc = rd_en && (mq[i].size() != 0);
        wacc = wr_en && ((mq[i].size() < D[i]) || racc);
        if (racc) hold[i] = mq[i].pop_front();
        if (wacc) mq[i].push_back(w_data);
        e.cnt  = mq[i].size();
        e.werr = wr_en && !wacc;
        e.rerr = rd_en && !racc;
`ifdef FIFO_FWFT_EN
        e.dchk = (mq[i].size() != 0);
        e.data = e.dchk ? mq[i][0] : 8'h00;
`else
        e.dchk = 1'b1;
        e.data = hold[i];
`endif
        eq[i].push_back(e);
      end
    end
  end

  // Monitor: after each edge, pop what the model predicted and compare against the DUT.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      if (eq[i].size() != 0) begin
        e = eq[i].pop_front();
        check("count", i, cnt_of(i), e.cnt);
        check("full", i, int'(full_o[i]), int'(e.cnt == D[i]));
        check("empty", i, int'(empty_o[i]), int'(e.cnt == 0));
        check("almost_full", i, int'(af_o[i]), int'(e.cnt >= AF[i]));
        check("almost_empty", i, int'(ae_o[i]), int'(e.cnt <= AE[i]));
        check("wr_error", i, int'(werr_o[i]), int'(e.werr));
        check("rd_error", i, int'(rerr_o[i]), int'(e.rerr));
        if (e.dchk) check("r_data", i, int'(r_data_o[i]), int'(e.data));
      end
    end
  end

  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    @(posedge clk);
    #3;
    wr_en  = w;
    rd_en  = r;
    w_data = d;
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_count"}, i, cnt_of(i), 0);
      check({tag, "_empty"}, i, int'(empty_o[i]), 1);
      check({tag, "_full"}, i, int'(full_o[i]), 0);
      check({tag, "_aempty"}, i, int'(ae_o[i]), 1);
      check({tag, "_afull"}, i, int'(af_o[i]), 0);
      check({tag, "_wr_error"}, i, int'(werr_o[i]), 0);
      check({tag, "_rd_error"}, i, int'(rerr_o[i]), 0);
`ifndef FIFO_FWFT_EN
      check({tag, "_r_data"}, i, int'(r_data_o[i]), 0);
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int pw;
    int pr;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(posedge clk);
    #3;
    rst = 1'b1;

    // Fill, overflow attempt, pass-through at full, then drain and underflow cases.
    for (int k = 0; k < 16; k++) drive(1'b1, 1'b0, 8'(k));
    drive(1'b1, 1'b0, 8'hAA);
    drive(1'b1, 1'b1, 8'h55);
    for (int k = 0; k < 16; k++) drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 8'h33);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 8'h00);

    // Repeated write-3/read-3 bursts walk the pointers around the DEPTH=5 wrap several times.
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 8'(8'h80 + n * 3 + k));
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 8'h00);
    end

    // Asynchronous reset in the middle of a burst.
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 8'(8'hC0 + k));
    drive(1'b0, 1'b1, 8'h00);
    @(posedge clk);
    #2;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    check_reset_state("midreset");
    @(posedge clk);
    #3;
    rst = 1'b1;

    for (int n = 0; n < 600; n++) begin
      pw = ((n / 100) % 2 == 0) ? 75 : 30;
      pr = 100 - pw;
      drive(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), 8'($urandom));
    end
    drive(1'b0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    check("drained", 0, eq[0].size() + eq[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
